// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory-stage controller and a
// multi-cycle data memory.
interface mem_stage_ctrl_if #(
    parameter int unsigned data_size = 32
) ();
    logic                 req;
    logic                 we;
    logic [data_size-1:0] addr;
    logic [data_size-1:0] wdata;
    logic [data_size-1:0] rdata;
    logic                 ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs req/ack accesses to a multi-cycle data memory, stalls upstream
// and feeds the Memory/Writeback register. Define DMEM_TIMEOUT_EN to enable the ack timeout.
module mem_stage_ctrl #(
    parameter int unsigned data_size = 32
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [data_size-1:0] ALUOutM,
    input  logic [data_size-1:0] WriteDataM,
    input  logic [4:0]           WriteRegM,
    input  logic                 RegWriteM,
    input  logic                 MemtoRegM,
    input  logic                 MemWriteM,
    output logic                 StallM,
    mem_stage_ctrl_if.master     dmem,
    output logic [data_size-1:0] ALUOutW,
    output logic [data_size-1:0] ReadDataW,
    output logic [4:0]           WriteRegW,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic [31:0]          StallCnt,
    output logic                 MemErr
);

    typedef enum logic {StIdle, StReq} state_e;

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [data_size-1:0] addr_q, addr_d;
    logic [data_size-1:0] wdata_q, wdata_d;
    logic [data_size-1:0] alu_w_q, alu_w_d;
    logic [data_size-1:0] rd_w_q, rd_w_d;
    logic [4:0]           wreg_w_q, wreg_w_d;
    logic                 regw_w_q, regw_w_d;
    logic                 m2r_w_q, m2r_w_d;
    logic [31:0]          stall_cnt_q, stall_cnt_d;

    logic access, ack_done, fault, done;

    // A simultaneous load+store request is treated as a store through we_d = MemWriteM.
    assign access   = MemtoRegM | MemWriteM;
    assign ack_done = (state_q == StReq) && dmem.ack;
    assign done     = ack_done | fault;
    assign StallM   = access & ~done;

`ifdef DMEM_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        mem_err_q, mem_err_d;

    // Counter sits at zero while idle, so it is already clear on entry to StReq.
    assign fault = (state_q == StReq) && !dmem.ack && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d  = to_cnt_q;
        mem_err_d = mem_err_q | fault;
        if (state_q == StIdle) begin
            to_cnt_d = 16'd0;
        end else if (!dmem.ack) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= 16'd0;
            mem_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign MemErr = mem_err_q;
`else
    assign fault  = 1'b0;
    assign MemErr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (access) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = ALUOutM;
                    wdata_d = WriteDataM;
                end
            end
            StReq: begin
                if (done) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_w_d     = alu_w_q;
        rd_w_d      = rd_w_q;
        wreg_w_d    = wreg_w_q;
        regw_w_d    = regw_w_q;
        m2r_w_d     = m2r_w_q;
        stall_cnt_d = stall_cnt_q;
        if (StallM) begin
            // Bubble: clear control, keep data so W-stage forwarding paths stay quiet.
            wreg_w_d = 5'd0;
            regw_w_d = 1'b0;
            m2r_w_d  = 1'b0;
            if (stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end else begin
            alu_w_d  = ALUOutM;
            wreg_w_d = WriteRegM;
            regw_w_d = RegWriteM;
            m2r_w_d  = MemtoRegM;
            if (fault) begin
                regw_w_d = 1'b0;
                rd_w_d   = '0;
            end else if (ack_done && !we_q) begin
                rd_w_d = dmem.rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            alu_w_q     <= '0;
            rd_w_q      <= '0;
            wreg_w_q    <= 5'd0;
            regw_w_q    <= 1'b0;
            m2r_w_q     <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            alu_w_q     <= alu_w_d;
            rd_w_q      <= rd_w_d;
            wreg_w_q    <= wreg_w_d;
            regw_w_q    <= regw_w_d;
            m2r_w_q     <= m2r_w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign ALUOutW    = alu_w_q;
    assign ReadDataW  = rd_w_q;
    assign WriteRegW  = wreg_w_q;
    assign RegWriteW  = regw_w_q;
    assign MemtoRegW  = m2r_w_q;
    assign StallCnt   = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: per-instruction reference model driven by the
// memory's ack delay; define DMEM_TIMEOUT_EN to also exercise the timeout fault.
module tb_mem_stage_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic        StallM;
    logic [31:0] ALUOutW, ReadDataW;
    logic [4:0]  WriteRegW;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] StallCnt;
    logic        MemErr;

    int checks = 0;
    int errors = 0;

    // Reference model of the architecturally visible state.
    logic [31:0] exp_alu_w, exp_rd_w, exp_stall_cnt;
    logic [4:0]  exp_wreg_w;
    logic        exp_regw_w, exp_m2r_w, exp_mem_err;

    mem_stage_ctrl_if #(.data_size(32)) dmem_bus ();

`ifdef DMEM_TIMEOUT_EN
    mem_stage_ctrl #(.data_size(32), .TIMEOUT_CYCLES(TO)) dut (
`else
    mem_stage_ctrl #(.data_size(32)) dut (
`endif
        .clk        (clk),
        .reset      (reset),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .WriteRegM  (WriteRegM),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .StallM     (StallM),
        .dmem       (dmem_bus),
        .ALUOutW    (ALUOutW),
        .ReadDataW  (ReadDataW),
        .WriteRegW  (WriteRegW),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .StallCnt   (StallCnt),
        .MemErr     (MemErr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic model_clear();
        exp_alu_w     = '0;
        exp_rd_w      = '0;
        exp_stall_cnt = '0;
        exp_wreg_w    = '0;
        exp_regw_w    = 1'b0;
        exp_m2r_w     = 1'b0;
        exp_mem_err   = 1'b0;
    endtask

    task automatic drive_idle();
        ALUOutM       = '0;
        WriteDataM    = '0;
        WriteRegM     = '0;
        RegWriteM     = 1'b0;
        MemtoRegM     = 1'b0;
        MemWriteM     = 1'b0;
        dmem_bus.ack  = 1'b0;
        dmem_bus.rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One instruction in M. dly = REQ cycles without ack before the ack cycle; -1 never acks.
    task automatic run_instr(input logic ld, input logic st, input logic rw,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] wr, input int dly, input logic [31:0] rd);
        logic acc, ack_now, fault_e, stall_e, fin;
        int   cyc;
        acc = ld | st;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            ALUOutM    = alu;
            WriteDataM = wd;
            WriteRegM  = wr;
            RegWriteM  = rw;
            MemtoRegM  = ld;
            MemWriteM  = st;
            ack_now = acc && cyc >= 1 && dly >= 0 && cyc == dly + 1;
            fault_e = acc && cyc >= 1 && !ack_now && TO > 0 && cyc == TO;
            stall_e = acc && !ack_now && !fault_e;
            // Occasional ack while idle must be ignored.
            dmem_bus.ack   = ack_now | (cyc == 0 && $urandom_range(0, 3) == 0);
            dmem_bus.rdata = ack_now ? rd : $urandom();
            #1;
            checks++;
            if (StallM !== stall_e) begin
                errors++;
                $display("FAIL stall_m cyc=%0d: got %b expected %b", cyc, StallM, stall_e);
            end
            checks++;
            if (cyc == 0) begin
                if (dmem_bus.req !== 1'b0) begin
                    errors++;
                    $display("FAIL req_idle: got %b expected 0", dmem_bus.req);
                end
            end else if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata} !==
                         {1'b1, st, alu, wd}) begin
                errors++;
                $display("FAIL req_bus cyc=%0d: got req=%b we=%b addr=%h wdata=%h expected req=1 we=%b addr=%h wdata=%h",
                         cyc, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata,
                         st, alu, wd);
            end
            @(posedge clk);
            #1;
            if (stall_e) begin
                if (exp_stall_cnt != 32'hFFFF_FFFF) exp_stall_cnt = exp_stall_cnt + 1;
                exp_wreg_w = '0;
                exp_regw_w = 1'b0;
                exp_m2r_w  = 1'b0;
            end else begin
                exp_alu_w  = alu;
                exp_wreg_w = wr;
                exp_regw_w = rw && !fault_e;
                exp_m2r_w  = ld;
                if (fault_e) begin
                    exp_rd_w    = '0;
                    exp_mem_err = 1'b1;
                end else if (ack_now && !st) begin
                    exp_rd_w = rd;
                end
                fin = 1'b1;
            end
            checks++;
            if ({ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW} !==
                {exp_alu_w, exp_rd_w, exp_wreg_w, exp_regw_w, exp_m2r_w}) begin
                errors++;
                $display("FAIL w_reg cyc=%0d: got alu=%h rd=%h wreg=%0d rw=%b m2r=%b expected alu=%h rd=%h wreg=%0d rw=%b m2r=%b",
                         cyc, ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW,
                         exp_alu_w, exp_rd_w, exp_wreg_w, exp_regw_w, exp_m2r_w);
            end
            checks++;
            if ({StallCnt, MemErr} !== {exp_stall_cnt, exp_mem_err}) begin
                errors++;
                $display("FAIL cnt_err cyc=%0d: got cnt=%h err=%b expected cnt=%h err=%b",
                         cyc, StallCnt, MemErr, exp_stall_cnt, exp_mem_err);
            end
            cyc++;
            if (!fin && cyc > 300) begin
                checks++;
                errors++;
                $display("FAIL instr_bound: got no completion after %0d cycles, expected completion", cyc);
                fin = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({StallM, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got stall=%b req=%b we=%b addr=%h wdata=%h expected all 0",
                     StallM, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata);
        end
        checks++;
        if ({ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW, StallCnt, MemErr} !== '0) begin
            errors++;
            $display("FAIL reset_w: got alu=%h rd=%h wreg=%0d rw=%b m2r=%b cnt=%h err=%b expected all 0",
                     ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW, StallCnt, MemErr);
        end
    endtask

    task automatic test_alu_op();
        run_instr(1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        checks++;
        if ({ALUOutW, WriteRegW, RegWriteW, dmem_bus.req} !== {32'h1234, 5'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL alu_op: got alu=%h wreg=%0d rw=%b req=%b expected 1234 5 1 0",
                     ALUOutW, WriteRegW, RegWriteW, dmem_bus.req);
        end
    endtask

    task automatic test_load();
        do_reset();
        run_instr(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd7, 2, 32'hDEAD_BEEF);
        checks++;
        if ({ReadDataW, MemtoRegW, RegWriteW, StallCnt} !== {32'hDEAD_BEEF, 1'b1, 1'b1, 32'd3}) begin
            errors++;
            $display("FAIL load_ack3: got rd=%h m2r=%b rw=%b cnt=%0d expected deadbeef 1 1 3",
                     ReadDataW, MemtoRegW, RegWriteW, StallCnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_instr(1'b0, 1'b1, 1'b0, 32'h10, 32'hAA, 5'd0, 0, 32'h0);
        run_instr(1'b0, 1'b1, 1'b0, 32'h14, 32'hBB, 5'd0, 0, 32'h0);
        checks++;
        if ({StallCnt, dmem_bus.req} !== {32'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_stores: got cnt=%0d req=%b expected 2 0", StallCnt, dmem_bus.req);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        @(negedge clk);
        MemtoRegM = 1'b1;
        RegWriteM = 1'b1;
        ALUOutM   = 32'h80;
        WriteRegM = 5'd9;
        @(negedge clk);
        #1;
        checks++;
        if (dmem_bus.req !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_setup: got req=%b expected 1", dmem_bus.req);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({dmem_bus.req, StallCnt, ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW} !== '0) begin
            errors++;
            $display("FAIL reset_mid_req: got req=%b cnt=%h alu=%h rd=%h wreg=%0d rw=%b m2r=%b expected all 0",
                     dmem_bus.req, StallCnt, ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        model_clear();
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (StallM !== 1'b0) begin
            errors++;
            $display("FAIL spurious_stall: got %b expected 0", StallM);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({dmem_bus.req, ReadDataW} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL spurious_ack: got req=%b rd=%h expected 0 0", dmem_bus.req, ReadDataW);
        end
        run_instr(1'b1, 1'b0, 1'b1, 32'h84, 32'h0, 5'd3, 1, 32'h5555_AAAA);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 2);
            run_instr(kind == 1, kind == 2, kind != 2, $urandom(), $urandom(),
                      5'($urandom_range(0, 31)), int'($urandom_range(0, 5)), $urandom());
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        drive_idle();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.stall_cnt_q;
        exp_stall_cnt = 32'hFFFF_FFFE;
        exp_alu_w  = '0;
        exp_wreg_w = '0;
        exp_regw_w = 1'b0;
        exp_m2r_w  = 1'b0;
        run_instr(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd1, 2, 32'h0BAD_F00D);
        checks++;
        if (StallCnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stall_sat: got %h expected ffffffff", StallCnt);
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        run_instr(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd4, -1, 32'h0);
        checks++;
        if ({MemErr, ReadDataW, RegWriteW, dmem_bus.req, StallCnt} !==
            {1'b1, 32'h0, 1'b0, 1'b0, 32'd4}) begin
            errors++;
            $display("FAIL timeout_fault: got err=%b rd=%h rw=%b req=%b cnt=%0d expected 1 0 0 0 4",
                     MemErr, ReadDataW, RegWriteW, dmem_bus.req, StallCnt);
        end
        run_instr(1'b1, 1'b0, 1'b1, 32'h204, 32'h0, 5'd4, 0, 32'h1357_9BDF);
        checks++;
        if ({MemErr, ReadDataW} !== {1'b1, 32'h1357_9BDF}) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b rd=%h expected 1 13579bdf", MemErr, ReadDataW);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_alu_op();
        test_load();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        test_saturation();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller on the consuming side of the Execute/Memory pipeline register.
- Takes the M-stage control and data signals and runs a req/ack transaction to a multi-cycle data memory.
- Stalls the upstream pipeline while an access is outstanding.
- Drives the Memory/Writeback pipeline register, inserting a bubble on every stalled cycle.

Parameters:
- data_size, 32, width of the data and address paths.
- TIMEOUT_CYCLES, 255, REQ cycles without ack before a timeout fault. Used only with DMEM_TIMEOUT_EN; range 1..65535.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ALUOutM  input  data_size  effective address or ALU result.
- WriteDataM  input  data_size  store data.
- WriteRegM  input  5  destination register.
- RegWriteM  input  1  register write enable.
- MemtoRegM  input  1  load (read access).
- MemWriteM  input  1  store (write access).
- StallM  output  1  combinational; holds PC/IF/ID/EX/MEM registers when 1.
- dmem_req  output  1  registered, memory request.
- dmem_we  output  1  registered, 1 = write.
- dmem_addr  output  data_size  registered address.
- dmem_wdata  output  data_size  registered write data.
- dmem_rdata  input  data_size  read data, valid in the dmem_ack cycle.
- dmem_ack  input  1  single-cycle completion strobe.
- ALUOutW  output  data_size  Memory/Writeback register ALU result.
- ReadDataW  output  data_size  Memory/Writeback register load data.
- WriteRegW  output  5  Memory/Writeback register destination.
- RegWriteW  output  1  Memory/Writeback register write enable.
- MemtoRegW  output  1  Memory/Writeback register result select.
- StallCnt  output  32  saturating count of StallM=1 cycles.
- MemErr  output  1  sticky memory fault flag.

Behaviour:
- Reset: synchronous, active-high, overrides everything.
  - All registered outputs become 0: dmem_*, *W, StallCnt, MemErr.
  - FSM goes to IDLE; the timeout counter clears.
  - Reset while in REQ abandons the transaction; dmem_req is 0 on the cycle after the reset edge.
- Access term: access = MemtoRegM | MemWriteM.
  - MemtoRegM=MemWriteM=1 is illegal upstream; treat it as a write.
- FSM has two states, IDLE and REQ.
  - IDLE with access=1:
    - Load dmem_addr<=ALUOutM, dmem_wdata<=WriteDataM, dmem_we<=MemWriteM, dmem_req<=1.
    - Go to REQ.
  - IDLE with access=0: stay in IDLE; dmem_req stays 0.
  - REQ: dmem_req, dmem_addr, dmem_wdata and dmem_we are held stable until the dmem_ack cycle.
  - REQ on ack: dmem_req<=0, go to IDLE.
- dmem_ack while in IDLE is spurious: ignored, no state change.
- StallM = access & ~(state==REQ & dmem_ack).
  - Minimum memory-instruction latency is 2 cycles: the issue cycle plus the ack cycle.
  - Back-to-back memory instructions re-enter REQ one cycle after each ack.
- Memory/Writeback register, every non-reset posedge:
  - StallM=1: insert a bubble. RegWriteW<=0, MemtoRegW<=0, WriteRegW<=0; ALUOutW and ReadDataW hold.
  - StallM=0: ALUOutW<=ALUOutM, WriteRegW<=WriteRegM, RegWriteW<=RegWriteM, MemtoRegW<=MemtoRegM.
  - StallM=0 on a completing read: ReadDataW<=dmem_rdata.
  - StallM=0 otherwise: ReadDataW holds.
  - A store passes through with its control bits as given; RegWriteM is expected to be 0.
- StallCnt increments by 1 on each cycle with StallM=1 and saturates at 32'hFFFFFFFF.
- No address alignment checking; dmem_addr is passed unmodified.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to REQ and increments on each REQ cycle without ack.
  - When the counter equals TIMEOUT_CYCLES-1 and ack=0, the transaction completes as a fault. That means: StallM=0 that cycle, dmem_req<=0, IDLE, MemErr<=1 (sticky until reset), ReadDataW<=0, RegWriteW<=0 for that instruction.
  - An ack in the same cycle wins over the timeout.
- Undefined:
  - REQ waits indefinitely.
  - MemErr is constant 0 and no counter is synthesized.

Test Plan:
- ALU op: RegWriteM=1, MemtoRegM=0, MemWriteM=0, ALUOutM=0x1234, WriteRegM=5 -> StallM=0; next edge ALUOutW=0x1234, WriteRegW=5, RegWriteW=1; dmem_req stays 0.
- Load, ack 3 cycles after req: MemtoRegM=1, ALUOutM=0x40, rdata=0xDEADBEEF -> dmem_req=1 and addr=0x40 for 3 cycles. StallM=1 for 3 cycles with bubbles in W, then ReadDataW=0xDEADBEEF, MemtoRegW=1, StallCnt=3.
- Back-to-back stores, ack the same cycle as req: 0x10/0xAA then 0x14/0xBB -> two distinct req windows, dmem_we=1, each with one stall cycle; StallCnt=2.
- Reset asserted in the middle of REQ -> next cycle dmem_req=0, StallCnt=0, all W outputs 0; a spurious ack afterwards is ignored.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack on a load -> fault after 4 REQ cycles: MemErr=1, ReadDataW=0, RegWriteW=0, FSM IDLE. MemErr remains 1 through later good accesses.
- StallCnt preset via force to 0xFFFFFFFE, then a 3-cycle stall -> StallCnt=0xFFFFFFFF (saturated).
